lshifter_norm: RTL and testbench
================================

Name: lshifter_norm

Overview:
Pipelined left-shift normalizer for the FPU. It is the counterpart of the right-shift alignment path and sits after add/sub and multiply, before rounding. It shifts a mantissa left until the MSB is 1, with the shift limited by an exponent budget so that denormal results are produced correctly. Each shift stage is registered, and the pipeline uses a valid/ready handshake on both sides.

Parameters:
n, 24, mantissa data bits; constraint 2**(s-1) <= n
s, 5, shift stages; maximum total shift is 2**s-1
e, 8, exponent bits (biased, unsigned)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in  input  n  unnormalized mantissa
exp_in  input  e  biased exponent of in
valid_in  input  1  upstream operand valid
ready_in  output  1  normalizer can accept an operand this cycle
out  output  n  normalized mantissa
exp_out  output  e  adjusted exponent
shamt  output  s  total left shift applied
zero  output  1  in was all zeros
valid_out  output  1  result valid
ready_out  input  1  downstream accepts result

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Shift budget: lim = exp_in-1 when exp_in > 0, otherwise 0. It is captured at stage entry and carried down the pipe.
- Stage order: stage k (k = 0..s-1) handles shift width w = 2**(s-1-k), so the largest shift comes first.
- Stage rule: shift the mantissa left by w (zero fill), add w to shamt and subtract w from the remaining budget, only if:
  - the top w bits of the mantissa are all 0, and
  - the remaining budget >= w.
  Otherwise the stage passes the value through unchanged.
- Final outputs:
  - exp_out = exp_in - shamt if out[n-1] = 1, else 0 (denormal or zero).
  - zero = (in == 0), carried through the pipe.
  - Zero input still runs the stage rule: out = 0, exp_out = 0, shamt = min(lim, 2**s-1).
- exp_in = 0: no shift occurs; out = in and exp_out = 0.
- Latency: s cycles from input acceptance (valid_in & ready_in) to valid_out, when there is no backpressure. Throughput is 1 result per cycle.
- Each stage holds one register slot (data, shamt, budget, exp_in, zero, valid).
- Stage k loads from stage k-1 when (!valid_k) | (advance of stage k+1). The last stage advances when !valid_out | ready_out.
- ready_in = !valid_0 | (stage 0 advances). This is combinational from ready_out through the chain of valids.
- Backpressure: when ready_out = 0 and all stages are full, all stages hold and ready_in = 0. No result is lost, duplicated or reordered.
- Bubbles: an empty stage always accepts, so bubbles collapse under backpressure.
- valid_in with ready_in = 0: the operand is not taken. Upstream must hold it stable.
- out, exp_out, shamt and zero are stable while valid_out & !ready_out.
- Reset: all valids clear and all data and outputs go to 0. Reset wins over any simultaneous handshake, and operands in flight mid-operation are discarded.
- First cycle after reset release: ready_in = 1, valid_out = 0.

Test Plan:
- in=0x000001, exp_in=100, ready_out=1 -> after 5 cycles: out=0x800000, shamt=23, exp_out=77, zero=0.
- in=0x000100, exp_in=5 (lim=4) -> out=0x001000, shamt=4, exp_out=0 (denormal).
- in=0x000000, exp_in=200 -> out=0, shamt=31, exp_out=0, zero=1. Also in=0x400000, exp_in=0 -> out=0x400000, shamt=0, exp_out=0.
- Stream 8 back-to-back operands; hold ready_out=0 for cycles 6-9 -> ready_in drops after the pipe fills, no loss, results emerge in order, output stable while stalled.
- Assert reset in the middle of a 3-operand stream -> next cycle valid_out=0, all outputs 0, ready_in=1; the discarded operands never appear.
- Random in/exp_in against a reference model (MSB search limited by the budget), 10k vectors with random valid_in and ready_out toggling -> bit-exact match on out, exp_out, shamt and zero.

Source files
------------

// File: rtl/lshifter_norm.sv
// Pipelined left-shift normalizer: shifts a mantissa left until its MSB is set,
// bounded by an exponent budget so that denormal results come out correctly.
// Ports: clk, reset (sync, active-high)
//   in/exp_in/valid_in/ready_in             upstream operand handshake
//   out/exp_out/shamt/zero/valid_out/ready_out  downstream result handshake
module lshifter_norm #(
  parameter int n = 24,
  parameter int s = 5,
  parameter int e = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] in,
  input  logic [e-1:0] exp_in,
  input  logic         valid_in,
  output logic         ready_in,
  output logic [n-1:0] out,
  output logic [e-1:0] exp_out,
  output logic [s-1:0] shamt,
  output logic         zero,
  output logic         valid_out,
  input  logic         ready_out
);

  logic [n-1:0] r_data [s];
  logic [s-1:0] r_sh   [s];
  logic [e-1:0] r_bud  [s];
  logic [e-1:0] r_exp  [s];
  logic [s-1:0] r_zero;
  logic [s-1:0] r_vld;

  logic [n-1:0] w_pd  [s];
  logic [s-1:0] w_psh [s];
  logic [e-1:0] w_pb  [s];
  logic [e-1:0] w_px  [s];
  logic [s-1:0] w_pz;
  logic [s-1:0] w_pv;

  logic [n-1:0] w_nd  [s];
  logic [s-1:0] w_nsh [s];
  logic [e-1:0] w_nb  [s];
  logic [s-1:0] w_tk;
  logic [s-1:0] w_ld;

  genvar k;
  generate
    for (k = 0; k < s; k++) begin : g_st
      localparam int W = 1 << (s - 1 - k);

      if (k == 0) begin : g_src
        // Budget is exp_in-1 so a normal result never reaches exponent 0.
        assign w_pd[k]  = in;
        assign w_psh[k] = '0;
        assign w_pb[k]  = (exp_in != '0) ? exp_in - e'(1) : '0;
        assign w_px[k]  = exp_in;
        assign w_pz[k]  = (in == '0);
        assign w_pv[k]  = valid_in;
      end else begin : g_src
        assign w_pd[k]  = r_data[k-1];
        assign w_psh[k] = r_sh[k-1];
        assign w_pb[k]  = r_bud[k-1];
        assign w_px[k]  = r_exp[k-1];
        assign w_pz[k]  = r_zero[k-1];
        assign w_pv[k]  = r_vld[k-1];
      end

      assign w_tk[k] = (w_pd[k][n-1 -: W] == '0)
                    && (w_pb[k] >= e'(W));

      assign w_nd[k]  = w_tk[k] ? (w_pd[k] << W) : w_pd[k];
      assign w_nsh[k] = w_tk[k] ? w_psh[k] + s'(W) : w_psh[k];
      assign w_nb[k]  = w_tk[k] ? w_pb[k] - e'(W) : w_pb[k];
    end
  endgenerate

  // A stage loads when it is empty or its successor is draining it;
  // walking from the output back lets bubbles collapse under stall.
  always_comb begin
    logic acc;
    acc = ready_out;
    w_ld = '0;
    for (int i = s - 1; i >= 0; i--) begin
      acc = acc | !r_vld[i];
      w_ld[i] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < s; i++) begin
        r_data[i] <= '0;
        r_sh[i]   <= '0;
        r_bud[i]  <= '0;
        r_exp[i]  <= '0;
      end
      r_zero <= '0;
      r_vld  <= '0;
    end else begin
      for (int i = 0; i < s; i++) begin
        if (w_ld[i]) begin
          r_data[i] <= w_nd[i];
          r_sh[i]   <= w_nsh[i];
          r_bud[i]  <= w_nb[i];
          r_exp[i]  <= w_px[i];
          r_zero[i] <= w_pz[i];
          r_vld[i]  <= w_pv[i];
        end
      end
    end
  end

  assign ready_in  = w_ld[0];
  assign out       = r_data[s-1];
  assign shamt     = r_sh[s-1];
  assign zero      = r_zero[s-1];
  assign valid_out = r_vld[s-1];

  // Unnormalized result means denormal or zero: exponent field is 0.
  assign exp_out = out[n-1] ? r_exp[s-1] - e'(r_sh[s-1]) : '0;

endmodule

// File: tb/tb_lshifter_norm.sv
// Scoreboard bench for lshifter_norm: directed cases, stall, mid-stream
// reset and random traffic against a leading-zero based reference model.
module tb_lshifter_norm;

  typedef struct {
    logic [23:0] o;
    logic [7:0]  x;
    logic [4:0]  sh;
    logic        z;
  } exp_t;

  logic        clk = 0;
  logic        reset;
  logic [23:0] in;
  logic [7:0]  exp_in;
  logic        valid_in;
  logic        ready_in;
  logic [23:0] out;
  logic [7:0]  exp_out;
  logic [4:0]  shamt;
  logic        zero;
  logic        valid_out;
  logic        ready_out;

  int checks = 0;
  int errors = 0;
  int dcyc = 0;
  int mode = 0;
  int stall_cnt = 0;
  exp_t q[$];

  lshifter_norm #(.n(24), .s(5), .e(8)) dut (
    .clk(clk), .reset(reset),
    .in(in), .exp_in(exp_in),
    .valid_in(valid_in), .ready_in(ready_in),
    .out(out), .exp_out(exp_out),
    .shamt(shamt), .zero(zero),
    .valid_out(valid_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Reference: shift = min(leading zeros, budget, 31); zero input has
  // unlimited leading zeros.
  function automatic exp_t model(input logic [23:0] a,
                                 input logic [7:0] ex);
    exp_t r;
    int lim, lz, sh;
    lim = (ex > 0) ? int'(ex) - 1 : 0;
    if (a == 0) lz = 31;
    else begin
      lz = 0;
      while (!a[23 - lz]) lz++;
    end
    sh = lz;
    if (lim < sh) sh = lim;
    if (31 < sh) sh = 31;
    r.o  = a << sh;
    r.sh = 5'(sh);
    r.z  = (a == 0);
    r.x  = r.o[23] ? 8'(int'(ex) - sh) : 8'd0;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    dcyc++;
    case (mode)
      1: ready_out = ($urandom % 4) != 0;
      2: ready_out = !(dcyc >= 6 && dcyc <= 9);
      default: ready_out = 1'b1;
    endcase
  endtask

  task automatic send(input logic [23:0] a,
                      input logic [7:0] ex,
                      input exp_t r);
    int g;
    g = 0;
    valid_in = 1'b1;
    in = a;
    exp_in = ex;
    #1;
    while (!ready_in && g < 1000) begin
      stall_cnt++;
      tick();
      #1;
      g++;
    end
    if (!ready_in) chk("send_timeout", 0, 1);
    else q.push_back(r);
    tick();
  endtask

  task automatic idle();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic drain();
    int g;
    g = 0;
    valid_in = 1'b0;
    mode = 0;
    while (q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    tick();
  endtask

  task automatic chk_idle(input string nm);
    #1;
    chk({nm, "_valid_out"}, 32'(valid_out), 0);
    chk({nm, "_ready_in"}, 32'(ready_in), 1);
    chk({nm, "_out"}, 32'(out), 0);
    chk({nm, "_exp_out"}, 32'(exp_out), 0);
    chk({nm, "_shamt"}, 32'(shamt), 0);
    chk({nm, "_zero"}, 32'(zero), 0);
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    exp_t r;
    logic pst;
    logic [23:0] h_o;
    logic [13:0] h_m;
    pst = 1'b0;
    h_o = '0;
    h_m = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        pst = 1'b0;
      end else begin
        if (pst) begin
          chk("stall_out", 32'(out), 32'(h_o));
          chk("stall_meta", 32'({exp_out, shamt, zero}), 32'(h_m));
        end
        if (valid_out && ready_out) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 32'(out), 32'hffff_ffff);
          end else begin
            r = q.pop_front();
            chk("out", 32'(out), 32'(r.o));
            chk("exp_out", 32'(exp_out), 32'(r.x));
            chk("shamt", 32'(shamt), 32'(r.sh));
            chk("zero", 32'(zero), 32'(r.z));
          end
        end
        pst = valid_out && !ready_out;
        h_o = out;
        h_m = {exp_out, shamt, zero};
      end
    end
  end

  initial begin
    exp_t r;
    int lat;
    logic [23:0] a;
    logic [7:0] ex;

    reset = 1'b1;
    valid_in = 1'b0;
    in = '0;
    exp_in = '0;
    ready_out = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_idle("post_reset");
    tick();

    r.o = 24'h800000; r.x = 8'd77; r.sh = 5'd23; r.z = 1'b0;
    send(24'h000001, 8'd100, r);
    valid_in = 1'b0;
    lat = 1;
    #1;
    while (!valid_out && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 5);
    drain();

    r.o = 24'h001000; r.x = 8'd0; r.sh = 5'd4; r.z = 1'b0;
    send(24'h000100, 8'd5, r);
    r.o = 24'h000000; r.x = 8'd0; r.sh = 5'd31; r.z = 1'b1;
    send(24'h000000, 8'd200, r);
    r.o = 24'h400000; r.x = 8'd0; r.sh = 5'd0; r.z = 1'b0;
    send(24'h400000, 8'd0, r);
    drain();

    // Eight back-to-back operands with ready_out low for cycles 6-9.
    ready_out = 1'b1;
    dcyc = 0;
    mode = 2;
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      a = 24'($urandom) >> $urandom_range(0, 12);
      ex = 8'($urandom_range(1, 255));
      send(a, ex, model(a, ex));
    end
    chk("stall_ready_in_low", 32'(stall_cnt > 0), 1);
    drain();

    // Reset with three operands in flight: they must never appear.
    for (int i = 0; i < 3; i++) begin
      a = 24'($urandom);
      ex = 8'($urandom);
      send(a, ex, model(a, ex));
    end
    valid_in = 1'b0;
    reset = 1'b1;
    q.delete();
    tick();
    reset = 1'b0;
    chk_idle("mid_reset");
    repeat (10) tick();
    chk("mid_reset_q", q.size(), 0);

    mode = 1;
    for (int i = 0; i < 10000; i++) begin
      a = 24'($urandom) >> $urandom_range(0, 24);
      if ($urandom % 4 == 0) ex = 8'($urandom_range(0, 30));
      else ex = 8'($urandom);
      if ($urandom % 3 == 0) idle();
      send(a, ex, model(a, ex));
    end
    drain();
    chk("final_valid_out", 32'(valid_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
